uart_p_arbiter: RTL and testbench
=================================

# uart_p_arbiter

Round-robin arbiter that shares the single register port of the UART peripheral register block (4-bit word address, 32-bit data, registered read data) between `NREQ` CPU-side requesters. Each request is one read or write transaction, and the requester gets an `ack` pulse with the read data. The block sits between the core bus decoders and the UART peripheral. It is the only master that drives the peripheral's `wea`/`addra`/`dina`.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `MAX_BURST`, 8: maximum back-to-back locked transactions per grant. Only used with `UART_ARB_LOCK_EN`.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester transaction request. Level signal, held until `ack`.
- `req_we`  in  NREQ: 1 = write, 0 = read.
- `req_addr`  in  4*NREQ: word address. Requester i uses bits [4i+3:4i].
- `req_wdata`  in  32*NREQ: write data. Requester i uses bits [32i+31:32i].
- `req_lock`  in  NREQ: keep the grant for the next transaction. Ignored without `UART_ARB_LOCK_EN`.
- `ack`  out  NREQ: one-hot, one-cycle completion pulse.
- `rdata`  out  32: read data, valid when any `ack` bit is high.
- `p_wea`  out  1: peripheral write enable.
- `p_addra`  out  4: peripheral address.
- `p_dina`  out  32: peripheral write data.
- `p_douta`  in  32: peripheral read data, registered one cycle after `p_addra`.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req` bit is set, pick a grantee by round-robin and go to ISSUE.
  - Search starts at `rr_ptr` and proceeds upward, wrapping at `NREQ-1`.
  - Capture the grantee's `we`, `addr` and `wdata` into registers.
- **ISSUE**
  - Drive `p_wea` = captured `we`, `p_addra` = captured `addr`, `p_dina` = captured `wdata`.
  - Go to RESP.
- **RESP**
  - `ack[grantee]` = 1 and `rdata` = `p_douta`.
  - For writes, `rdata` carries whatever the peripheral returns and is don't-care to the requester.
  - Set `rr_ptr` to grantee+1, or 0 if grantee = `NREQ-1`.
  - Go to IDLE, except in the locked case below.
- Outside ISSUE: `p_wea` = 0, `p_addra` = 0, `p_dina` = 0.
- Outside RESP: `ack` = 0 and `rdata` = 0.
- Changes to `req` or payload after capture do not affect the transaction in flight.
- A requester holding `req` high through `ack` is treated as issuing a new request. It re-enters arbitration in the next IDLE.
- Dropping `req` mid-transaction does not abort it: `ack` still fires.
- The block does not interpret peripheral address semantics. Every access is a plain register read or write.

## Timing
- Unlocked transaction: `req` sampled in IDLE at cycle T, peripheral port driven at T+1, `ack`/`rdata` at T+2. Latency is 3 cycles, and at most one transaction completes every 3 cycles.
- Reset: state = IDLE and `rr_ptr` = 0. All outputs are 0 in the cycle after `rst` is sampled high.
- Reset mid-transaction: the transaction is dropped and no `ack` is issued. `p_wea` is low from the next cycle.
- Simultaneous requests: exactly one grant. No requester waits more than `NREQ-1` transactions (unlocked).
- Single requester: it is granted every IDLE, regardless of `rr_ptr`.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In RESP, if `req_lock[grantee]` and `req[grantee]` are both 1 and the burst count is below `MAX_BURST-1`: go directly to ISSUE, recapture the grantee's payload, increment the burst count, and leave `rr_ptr` unchanged.
  - This gives back-to-back transactions, one `ack` every 2 cycles.
  - The burst count resets to 0 on each new IDLE grant.
  - When `MAX_BURST` is reached, the lock is ignored, `rr_ptr` advances, and the FSM goes to IDLE.
  - Intended use: atomic status-poll-then-read of the RX register pair.
- `UART_ARB_LOCK_EN` not defined: `req_lock` is unused, there is no burst counter, and every transaction returns to IDLE.

## Structure
- Shared package `uart_arb_pkg` holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - UART register address constants: 0 rx_empty, 1 rd strobe, 2 rx data, 3 tx data, 4 tx count, 5 tx_full.
- One sub-module: `rr_pick`, combinational round-robin priority picker. Inputs are `req` and `rr_ptr`; outputs are a one-hot grant and its index. Everything else stays in the top.

## Test plan
- Single read: requester 1 reads addr 2, with the peripheral returning 32'h0000_0041 -> `p_addra`=2 at T+1, `ack`=3'b010 and `rdata`=32'h41 at T+2.
- Single write: requester 0 writes 32'h55 to addr 3 -> `p_wea`=1, `p_addra`=3, `p_dina`=32'h55 for exactly one cycle, then `ack[0]`.
- Fairness: all three requesters held high for 6 transactions starting from reset -> grant order 0,1,2,0,1,2.
- Reset in ISSUE: `rst` asserted during a write to addr 4 -> no `ack` follows, and the next grant after reset goes to the lowest-indexed requesting port.
- Lock (with `UART_ARB_LOCK_EN`, `MAX_BURST`=8): requester 2 locks while requester 0 requests -> 8 consecutive `ack[2]` pulses 2 cycles apart, then `ack[0]`.
- Lock compiled out: same stimulus -> alternating `ack[2]`, `ack[0]`, each 3 cycles apart.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART register-port arbiter: FSM encoding and
// the UART peripheral register map.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic [3:0] UART_ADDR_RX_EMPTY = 4'd0;
    localparam logic [3:0] UART_ADDR_RD_STB   = 4'd1;
    localparam logic [3:0] UART_ADDR_RX_DATA  = 4'd2;
    localparam logic [3:0] UART_ADDR_TX_DATA  = 4'd3;
    localparam logic [3:0] UART_ADDR_TX_COUNT = 4'd4;
    localparam logic [3:0] UART_ADDR_TX_FULL  = 4'd5;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping past NREQ-1; returns a one-hot grant and its index.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] gnt_idx_o
);

    logic            found;
    int              cand;
    logic [IDXW-1:0] cand_idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_i) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IDXW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                gnt_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_p_arbiter.sv
// Round-robin arbiter sharing the UART register port; 3-cycle transactions.
// Define UART_ARB_LOCK_EN to let a requester hold the grant for up to MAX_BURST transactions.
module uart_p_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [4*NREQ-1:0]  req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    ack,
    output logic [31:0]        rdata,
    output logic               p_wea,
    output logic [3:0]         p_addra,
    output logic [31:0]        p_dina,
    input  logic [31:0]        p_douta
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic            we_q, we_d;
    logic [3:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cap_idx;
    logic [IDXW-1:0] next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx)
    );

    // A fresh grant captures from the picker; a locked re-issue recaptures the holder.
    assign cap_idx  = (state_q == ST_IDLE) ? pick_idx : gnt_idx_q;
    assign next_ptr = (gnt_idx_q == IDXW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;

`ifdef UART_ARB_LOCK_EN
    localparam int BURSTW = $clog2(MAX_BURST) + 1;
    logic [BURSTW-1:0] burst_q, burst_d;
    logic              lock_hold;

    assign lock_hold = req_lock[gnt_idx_q] && req[gnt_idx_q]
                       && (burst_q < BURSTW'(MAX_BURST - 1));
`else
    logic unused_lock;
    assign unused_lock = ^{req_lock, MAX_BURST[0]};
`endif

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef UART_ARB_LOCK_EN
        burst_d   = burst_q;
`endif
        ack       = '0;
        rdata     = '0;
        p_wea     = 1'b0;
        p_addra   = '0;
        p_dina    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    state_d   = ST_ISSUE;
                    gnt_idx_d = pick_idx;
                    we_d      = req_we[cap_idx];
                    addr_d    = req_addr[int'(cap_idx)*4 +: 4];
                    wdata_d   = req_wdata[int'(cap_idx)*32 +: 32];
`ifdef UART_ARB_LOCK_EN
                    burst_d   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                p_wea   = we_q;
                p_addra = addr_q;
                p_dina  = wdata_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ack[gnt_idx_q] = 1'b1;
                rdata          = p_douta;
`ifdef UART_ARB_LOCK_EN
                if (lock_hold) begin
                    state_d = ST_ISSUE;
                    we_d    = req_we[cap_idx];
                    addr_d  = req_addr[int'(cap_idx)*4 +: 4];
                    wdata_d = req_wdata[int'(cap_idx)*32 +: 32];
                    burst_d = burst_q + 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
`else
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef UART_ARB_LOCK_EN
            burst_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef UART_ARB_LOCK_EN
            burst_q   <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_p_arbiter.sv
// Directed bench for uart_p_arbiter with a registered-read peripheral model.
module tb_uart_p_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [4*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    ack;
    logic [31:0]        rdata;
    logic               p_wea;
    logic [3:0]         p_addra;
    logic [31:0]        p_dina;
    logic [31:0]        p_douta;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    uart_p_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .ack       (ack),
        .rdata     (rdata),
        .p_wea     (p_wea),
        .p_addra   (p_addra),
        .p_dina    (p_dina),
        .p_douta   (p_douta)
    );

    always #5 clk = ~clk;

    // Peripheral: written registers read back, others return a fixed pattern.
    logic [31:0] mem [16];
    logic [15:0] wr_vld = '0;

    function automatic logic [31:0] rom(input logic [3:0] a);
        return (a == UART_ADDR_RX_DATA) ? 32'h41 : 32'hA0 + {28'h0, a};
    endfunction

    always @(posedge clk) begin
        if (p_wea) begin
            mem[p_addra]    <= p_dina;
            wr_vld[p_addra] <= 1'b1;
        end
        p_douta <= wr_vld[p_addra] ? mem[p_addra] : rom(p_addra);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  exp_ack;
        logic [31:0] exp_rd;
        int          exp_cyc;
        int          ev;

        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_lock = '0;
        tick(); tick();
        chk("rst_ack", ack === 3'b000, ack, 3'b000);
        chk("rst_rdata", rdata === 32'h0, rdata, 32'h0);
        chk("rst_wea", p_wea === 1'b0, p_wea, 1'b0);
        chk("rst_addra", p_addra === 4'h0, p_addra, 4'h0);
        chk("rst_dina", p_dina === 32'h0, p_dina, 32'h0);
        rst = 1'b0;

        // Single read: requester 1, RX data register
        req = 3'b010; req_addr[7:4] = UART_ADDR_RX_DATA;
        tick();
        chk("rd_issue_addr", p_addra === 4'd2, p_addra, 4'd2);
        chk("rd_issue_we", p_wea === 1'b0, p_wea, 1'b0);
        chk("rd_issue_noack", ack === 3'b000, ack, 3'b000);
        tick();
        chk("rd_ack", ack === 3'b010, ack, 3'b010);
        chk("rd_rdata", rdata === 32'h0000_0041, rdata, 32'h0000_0041);
        chk("rd_resp_addra", p_addra === 4'd0, p_addra, 4'd0);
        req = '0;
        tick();
        chk("rd_ack_one_cycle", ack === 3'b000, ack, 3'b000);
        chk("rd_rdata_cleared", rdata === 32'h0, rdata, 32'h0);

        // Single write: requester 0 granted even though rr_ptr points at 2
        req_we = 3'b001; req_addr[3:0] = UART_ADDR_TX_DATA; req_wdata[31:0] = 32'h55; req = 3'b001;
        tick();
        chk("wr_issue_wea", p_wea === 1'b1, p_wea, 1'b1);
        chk("wr_issue_addra", p_addra === 4'd3, p_addra, 4'd3);
        chk("wr_issue_dina", p_dina === 32'h55, p_dina, 32'h55);
        chk("wr_issue_noack", ack === 3'b000, ack, 3'b000);
        tick();
        chk("wr_resp_wea", p_wea === 1'b0, p_wea, 1'b0);
        chk("wr_resp_dina", p_dina === 32'h0, p_dina, 32'h0);
        chk("wr_ack", ack === 3'b001, ack, 3'b001);
        chk("wr_mem", mem[3] === 32'h55, mem[3], 32'h55);
        req = '0; req_we = '0;
        tick();

        // Fairness from reset: all three held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_addr = {4'd7, 4'd6, 4'd5}; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_ack = 3'b001 << (k % 3);
            exp_rd  = 32'hA5 + 32'(k % 3);
            tick(); tick();
            chk("fair_ack", ack === exp_ack, ack, exp_ack);
            chk("fair_rdata", rdata === exp_rd, rdata, exp_rd);
            tick();
            chk("fair_idle_noack", ack === 3'b000, ack, 3'b000);
        end
        req = '0;
        tick();

        // Move rr_ptr to 2, then reset during a write by requester 2
        req = 3'b010;
        tick(); tick();
        chk("pre_rst_ack", ack === 3'b010, ack, 3'b010);
        req = '0;
        tick();
        req_we = 3'b100; req_addr[11:8] = UART_ADDR_TX_COUNT; req_wdata[95:64] = 32'h77; req = 3'b100;
        tick();
        chk("rst_issue_wea", p_wea === 1'b1, p_wea, 1'b1);
        chk("rst_issue_addra", p_addra === 4'd4, p_addra, 4'd4);
        chk("rst_issue_dina", p_dina === 32'h77, p_dina, 32'h77);
        rst = 1'b1; req = 3'b110;
        tick();
        chk("rst_mid_wea", p_wea === 1'b0, p_wea, 1'b0);
        chk("rst_mid_addra", p_addra === 4'd0, p_addra, 4'd0);
        chk("rst_mid_noack", ack === 3'b000, ack, 3'b000);
        rst = 1'b0; req_we = '0;
        tick();
        chk("post_rst_noack", ack === 3'b000, ack, 3'b000);
        chk("post_rst_addra", p_addra === 4'd6, p_addra, 4'd6);
        tick();
        chk("post_rst_ack", ack === 3'b010, ack, 3'b010);
        req = '0;
        tick();

        // Requester 2 locks while requester 0 requests (rr_ptr is 2 here)
        req_addr[11:8] = UART_ADDR_RX_DATA; req_addr[3:0] = UART_ADDR_RX_EMPTY;
        req_lock = 3'b100; req = 3'b101;
        ev = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (ack != 3'b000) begin
                if (ev < 9) begin
`ifdef UART_ARB_LOCK_EN
                    exp_ack = (ev < 8) ? 3'b100 : 3'b001;
                    exp_cyc = (ev < 8) ? 2 + 2 * ev : 19;
`else
                    exp_ack = (ev % 2 == 0) ? 3'b100 : 3'b001;
                    exp_cyc = 2 + 3 * ev;
`endif
                    exp_rd = (exp_ack == 3'b100) ? 32'h41 : 32'hA0;
                    chk("lock_ack", ack === exp_ack, ack, exp_ack);
                    chk("lock_cycle", cyc === exp_cyc, cyc, exp_cyc);
                    chk("lock_rdata", rdata === exp_rd, rdata, exp_rd);
                end
                ev++;
            end
        end
        chk("lock_event_count", ev >= 9, ev, 9);
        req = '0; req_lock = '0;
        tick(); tick(); tick();
        chk("final_idle_ack", ack === 3'b000, ack, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
